gpio_sel_regs: RTL and testbench

// Wishbone-slave register bank that holds the 38 per-pin 4-bit source selects feeding the GPIO output mux.

---
 rtl/gpio_sel_regs.sv | 141 ++++++++++++++
 tb/tb_gpio_sel_regs.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_sel_regs.sv
// Wishbone register bank for the 38 GPIO output-mux source selects.
// Shadow selects are written by software and copied to the active map atomically on COMMIT; LOCK freezes the map.
module gpio_sel_regs #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned NUM_SRC   = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [3:0]  pin_0to7_sel   [7:0],
    output logic [3:0]  pin_8to15_sel  [7:0],
    output logic [3:0]  pin_16to23_sel [7:0],
    output logic [3:0]  pin_24to31_sel [7:0],
    output logic [3:0]  pin_32to37_sel [5:0],
    output logic        cfg_pending,
    output logic        cfg_locked
);

    localparam int unsigned NUM_WORDS = 5;
    localparam logic [4:0]  NUM_SRC_W = NUM_SRC[4:0];

    // An out-of-range source would steer a pad to an undefined mux input, so it collapses to source 0.
    function automatic logic [7:0] clean_byte(input logic [7:0] b);
        logic [7:0] r;
        if ({1'b0, b[3:0]} >= NUM_SRC_W) r[3:0] = 4'h0;
        else                             r[3:0] = b[3:0];
        if ({1'b0, b[7:4]} >= NUM_SRC_W) r[7:4] = 4'h0;
        else                             r[7:4] = b[7:4];
        return r;
    endfunction

    logic [31:0] shadow_r     [NUM_WORDS];
    logic [31:0] active_r     [NUM_WORDS];
    logic [31:0] shadow_nxt_s [NUM_WORDS];
    logic        lock_r;
    logic        ack_r;
    logic [31:0] dat_r;
    logic        hit_s;
    logic        sel_wr_s;
    logic        ctrl_wr_s;
    logic        commit_s;
    logic        lock_set_s;
    logic        pending_s;
    logic [2:0]  word_s;
    logic [31:0] rdata_s;
    logic        unused_s;

    // Decode of the current bus request
    always_comb begin
        word_s     = wbs_adr_i[4:2];
        hit_s      = wbs_cyc_i & wbs_stb_i & ~ack_r & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
        sel_wr_s   = hit_s & wbs_we_i & ~lock_r & (word_s < 3'd5);
        ctrl_wr_s  = hit_s & wbs_we_i & (word_s == 3'd5) & wbs_sel_i[0];
        commit_s   = ctrl_wr_s & wbs_dat_i[0] & ~lock_r;
        lock_set_s = ctrl_wr_s & wbs_dat_i[1];
    end

    // Shadow vs active difference
    always_comb begin
        pending_s = 1'b0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (shadow_r[w] != active_r[w]) pending_s = 1'b1;
            else                            pending_s = pending_s;
        end
    end

    // Read data mux
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (word_s)
            3'd0:    rdata_s = shadow_r[0];
            3'd1:    rdata_s = shadow_r[1];
            3'd2:    rdata_s = shadow_r[2];
            3'd3:    rdata_s = shadow_r[3];
            3'd4:    rdata_s = shadow_r[4];
            3'd5:    rdata_s = {29'h0000_0000, pending_s, lock_r, 1'b0};
            default: rdata_s = 32'h0000_0000;
        endcase
    end

    // Next shadow state with per-byte enables and source sanitising
    always_comb begin
        for (int w = 0; w < NUM_WORDS; w++) begin
            shadow_nxt_s[w] = shadow_r[w];
            for (int b = 0; b < 4; b++) begin
                if (sel_wr_s && (word_s == 3'(w)) && wbs_sel_i[b])
                    shadow_nxt_s[w][8*b +: 8] = clean_byte(wbs_dat_i[8*b +: 8]);
                else
                    shadow_nxt_s[w][8*b +: 8] = shadow_r[w][8*b +: 8];
            end
        end
        // Only pins 32-37 exist in the last word
        shadow_nxt_s[4][31:24] = 8'h00;
    end

    // Register bank, lock and bus handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                shadow_r[w] <= 32'h0000_0000;
                active_r[w] <= 32'h0000_0000;
            end
            lock_r <= 1'b0;
            ack_r  <= 1'b0;
            dat_r  <= 32'h0000_0000;
        end else begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                shadow_r[w] <= shadow_nxt_s[w];
                if (commit_s) active_r[w] <= shadow_r[w];
                else          active_r[w] <= active_r[w];
            end
            lock_r <= lock_r | lock_set_s;
            ack_r  <= hit_s;
            dat_r  <= hit_s ? rdata_s : 32'h0000_0000;
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_pin_bank
        assign pin_0to7_sel[g]   = active_r[0][4*g +: 4];
        assign pin_8to15_sel[g]  = active_r[1][4*g +: 4];
        assign pin_16to23_sel[g] = active_r[2][4*g +: 4];
        assign pin_24to31_sel[g] = active_r[3][4*g +: 4];
    end
    for (genvar g = 0; g < 6; g++) begin : g_pin_hi
        assign pin_32to37_sel[g] = active_r[4][4*g +: 4];
    end

    assign wbs_ack_o   = ack_r;
    assign wbs_dat_o   = dat_r;
    assign cfg_pending = pending_s;
    assign cfg_locked  = lock_r;
    assign unused_s    = ^{wbs_adr_i[1:0], active_r[4][31:24]};

endmodule

// File: tb/tb_gpio_sel_regs.sv
// Self-checking bench for gpio_sel_regs: per-pin nibble model checked every cycle plus directed literal checks.
module tb_gpio_sel_regs;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_we_i  = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = 32'h0;
    logic [31:0] wbs_dat_i = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [3:0]  pin_0to7_sel   [7:0];
    logic [3:0]  pin_8to15_sel  [7:0];
    logic [3:0]  pin_16to23_sel [7:0];
    logic [3:0]  pin_24to31_sel [7:0];
    logic [3:0]  pin_32to37_sel [5:0];
    logic        cfg_pending;
    logic        cfg_locked;

    int n_checks = 0;
    int n_fail   = 0;

    gpio_sel_regs #(.BASE_ADDR(BASE), .NUM_SRC(13)) dut (
        .clk(clk), .rst(rst),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .pin_0to7_sel(pin_0to7_sel), .pin_8to15_sel(pin_8to15_sel),
        .pin_16to23_sel(pin_16to23_sel), .pin_24to31_sel(pin_24to31_sel),
        .pin_32to37_sel(pin_32to37_sel),
        .cfg_pending(cfg_pending), .cfg_locked(cfg_locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model: one nibble per pin ----------------
    int unsigned shd [38];
    int unsigned act [38];
    bit          m_lock;
    bit          m_ack;
    logic [31:0] m_dat;
    bit          started = 1'b0;

    function automatic bit m_pending();
        for (int i = 0; i < 38; i++) if (shd[i] != act[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input int off);
        logic [31:0] v = 32'h0;
        if (off <= 16) begin
            for (int k = 0; k < 8; k++)
                if (off * 2 + k < 38) v[4*k +: 4] = 4'(shd[off * 2 + k]);
        end else if (off == 20) begin
            v[1] = m_lock;
            v[2] = m_pending();
        end
        return v;
    endfunction

    task automatic m_write(input int off, input logic [3:0] sel, input logic [31:0] dat);
        int unsigned val;
        int pin;
        if (off <= 16 && !m_lock) begin
            for (int b = 0; b < 4; b++)
                if (sel[b])
                    for (int n = 0; n < 2; n++) begin
                        pin = off * 2 + b * 2 + n;
                        val = int'(dat[8*b + 4*n +: 4]);
                        if (pin < 38) shd[pin] = (val >= 13) ? 0 : val;
                    end
        end else if (off == 20 && sel[0]) begin
            if (dat[0] && !m_lock) for (int i = 0; i < 38; i++) act[i] = shd[i];
            if (dat[1]) m_lock = 1'b1;
        end
    endtask

    initial begin : model
        bit hit;
        forever begin
            @(posedge clk);
            started = 1'b1;
            if (rst) begin
                for (int i = 0; i < 38; i++) begin shd[i] = 0; act[i] = 0; end
                m_lock = 1'b0; m_ack = 1'b0; m_dat = 32'h0;
            end else begin
                hit = wbs_cyc_i && wbs_stb_i && !m_ack && (wbs_adr_i[31:5] == BASE[31:5]);
                if (hit) begin
                    m_dat = m_read(int'(wbs_adr_i[4:2]) * 4);
                    if (wbs_we_i) m_write(int'(wbs_adr_i[4:2]) * 4, wbs_sel_i, wbs_dat_i);
                end else begin
                    m_dat = 32'h0;
                end
                m_ack = hit;
            end
        end
    end

    function automatic logic [3:0] dut_pin(input int i);
        if (i < 8)  return pin_0to7_sel[i];
        if (i < 16) return pin_8to15_sel[i - 8];
        if (i < 24) return pin_16to23_sel[i - 16];
        if (i < 32) return pin_24to31_sel[i - 24];
        return pin_32to37_sel[i - 32];
    endfunction

    initial begin : compare
        forever begin
            @(negedge clk);
            if (started) begin
                check("ack", {31'h0, wbs_ack_o}, {31'h0, m_ack});
                if (m_ack) check("rdata", wbs_dat_o, m_dat);
                check("locked", {31'h0, cfg_locked}, {31'h0, m_lock});
                check("pending", {31'h0, cfg_pending}, {31'h0, m_pending()});
                for (int i = 0; i < 38; i++)
                    check($sformatf("pin%0d", i), {28'h0, dut_pin(i)}, act[i]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic bus(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                       input logic [31:0] dat, output logic [31:0] rd, output bit acked);
        acked = 1'b0;
        rd = 32'h0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
        for (int c = 0; c < 4 && !acked; c++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) begin acked = 1'b1; rd = wbs_dat_o; end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [3:0] sel, input logic [31:0] dat);
        logic [31:0] rd; bit acked;
        bus(BASE + off, 1'b1, sel, dat, rd, acked);
        check($sformatf("wr_ack@%0h", off), {31'h0, acked}, 32'h1);
    endtask

    task automatic rd_exp(input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] rd; bit acked;
        bus(BASE + off, 1'b0, 4'hF, 32'h0, rd, acked);
        check($sformatf("rd_ack@%0h", off), {31'h0, acked}, 32'h1);
        check($sformatf("rd@%0h", off), rd, exp);
    endtask

    initial begin : stim
        logic [31:0] rd;
        bit acked;
        int acks;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: reset state
        for (int o = 0; o < 32; o += 4) rd_exp(32'(o), 32'h0);
        check("pin0_reset", {28'h0, pin_0to7_sel[0]}, 32'h0);

        // 2: shadow write then commit
        wr(32'h00, 4'hF, 32'h7654_3210);
        rd_exp(32'h00, 32'h7654_3210);
        check("pin3_before_commit", {28'h0, pin_0to7_sel[3]}, 32'h0);
        check("pending_set", {31'h0, cfg_pending}, 32'h1);
        wr(32'h14, 4'hF, 32'h1);
        check("pin5_committed", {28'h0, pin_0to7_sel[5]}, 32'h5);
        check("pending_clear", {31'h0, cfg_pending}, 32'h0);

        // 3: byte enables and invalid nibbles
        wr(32'h04, 4'b0011, 32'hFEDC_BA98);
        rd_exp(32'h04, 32'h0000_BA98);
        wr(32'h04, 4'b0100, 32'h00DC_0000);
        rd_exp(32'h04, 32'h000C_BA98);

        // 4: partial top word
        wr(32'h10, 4'hF, 32'hFF12_3456);
        rd_exp(32'h10, 32'h0012_3456);
        wr(32'h14, 4'hF, 32'h1);
        check("pin37", {28'h0, pin_32to37_sel[5]}, 32'h1);
        check("pin32", {28'h0, pin_32to37_sel[0]}, 32'h6);
        check("pin10", {28'h0, pin_8to15_sel[2]}, 32'hA);

        // 5: commit + lock together, then locked writes ignored
        wr(32'h00, 4'hF, 32'h1111_1111);
        wr(32'h14, 4'hF, 32'h3);
        check("pin0_commit_lock", {28'h0, pin_0to7_sel[0]}, 32'h1);
        check("locked", {31'h0, cfg_locked}, 32'h1);
        wr(32'h00, 4'hF, 32'h2222_2222);
        rd_exp(32'h00, 32'h1111_1111);
        wr(32'h14, 4'hF, 32'h1);
        check("pin0_locked", {28'h0, pin_0to7_sel[0]}, 32'h1);
        rd_exp(32'h14, 32'h0000_0002);
        rd_exp(32'h1C, 32'h0);

        // back-to-back requests acked every other cycle
        acks = 0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE; wbs_sel_i = 4'hF;
        repeat (4) begin @(posedge clk); #1; if (wbs_ack_o) acks++; end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge clk); #1;
        check("b2b_acks", 32'(acks), 32'd2);

        // 6: outside window, reset during accepted write
        bus(BASE + 32'h20, 1'b0, 4'hF, 32'h0, rd, acked);
        check("no_ack_outside", {31'h0, acked}, 32'h0);
        rst = 1'b1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
        wbs_adr_i = BASE + 32'h08; wbs_dat_i = 32'h1234_5678;
        @(posedge clk); #1;
        check("no_ack_in_reset", {31'h0, wbs_ack_o}, 32'h0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        rst = 1'b0;
        check("lock_cleared", {31'h0, cfg_locked}, 32'h0);
        check("pin0_cleared", {28'h0, pin_0to7_sel[0]}, 32'h0);
        rd_exp(32'h08, 32'h0);
        rd_exp(32'h00, 32'h0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
